// File: rtl/fixed2bfp_block.sv
// Purpose: fixed-point complex stream to block-floating-point (mantissas + one shared exponent per block).
// Latency: first mantissa 3 cycles after the last input sample of a block, then BLK_LEN back-to-back outputs.
// Backpressure: none; ping-pong banks absorb one block while the other replays at one sample per cycle.
module fixed2bfp_block #(
   parameter int IN_WIDTH  = 16,
   parameter int IN_PTPOS  = 15,
   parameter int MAN_WIDTH = 16,
   parameter int EXP_WIDTH = 8,
   parameter int BLK_LEN   = 64
) (
   input  logic                        clk_sys,
   input  logic                        rst_sys_n,
   input  logic                        block_sync_i,
   input  logic                        data_val_i,
   input  logic signed [IN_WIDTH-1:0]  data_real_i,
   input  logic signed [IN_WIDTH-1:0]  data_imag_i,
   output logic                        block_sync_o,
   output logic                        data_val_o,
   output logic signed [MAN_WIDTH-1:0] data_real_o,
   output logic signed [MAN_WIDTH-1:0] data_imag_o,
   output logic signed [EXP_WIDTH-1:0] data_exp_o
);

   localparam int AW = $clog2(BLK_LEN);
   localparam int HW = $clog2(IN_WIDTH);
   localparam int DW = 2 * IN_WIDTH;
   localparam int WW = IN_WIDTH + MAN_WIDTH + 2;
   localparam logic signed [WW-1:0] MAX_M = WW'((1 <<< (MAN_WIDTH - 1)) - 1);

   // Redundant sign bits: leading bits equal to the MSB, not counting the MSB itself.
   function automatic logic [HW-1:0] headroom(input logic [IN_WIDTH-1:0] v);
      logic [HW-1:0] n;
      logic          run;
      n   = '0;
      run = 1'b1;
      for (int i = IN_WIDTH - 2; i >= 0; i--) begin
         if (run && (v[i] == v[IN_WIDTH-1])) n = n + HW'(1);
         else run = 1'b0;
      end
      return n;
   endfunction

   function automatic logic [HW-1:0] hmin(input logic [HW-1:0] a, input logic [HW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Normalize one component: left shift, or right shift rounded half away from zero,
   // then clip symmetrically so the most negative code never appears.
   function automatic logic signed [MAN_WIDTH-1:0] norm(input logic signed [IN_WIDTH-1:0] x,
                                                        input int sh);
      logic signed [WW-1:0] xe, mag, half, y;
      xe = WW'(x);
      if (sh >= 0) begin
         y = xe <<< sh;
      end else begin
         mag  = xe[WW-1] ? -xe : xe;
         half = WW'(1) <<< (-sh - 1);
         mag  = (mag + half) >>> (-sh);
         y    = xe[WW-1] ? -mag : mag;
      end
      if (y > MAX_M) y = MAX_M;
      else if (y < -MAX_M) y = -MAX_M;
      return y[MAN_WIDTH-1:0];
   endfunction

   logic                armed, wr_bank;
   logic [AW-1:0]       wr_cnt, wr_addr;
   logic [HW-1:0]       h_run, h_smp, h_acc;
   logic [HW-1:0]       bank_h [2];
   logic [1:0]          full;
   logic                wr_en, close;
   logic                rd_busy, rd_bank, rd_ptr, rd_last, rd_start;
   logic [AW-1:0]       rd_addr;
   logic [HW-1:0]       rd_h, h_b;
   logic                vld_b, sync_b;
   logic [DW-1:0]       mem [2*BLK_LEN];
   logic [DW-1:0]       ram_q;
   int                  sh_amt;
   logic signed [EXP_WIDTH-1:0] exp_b;

   // Write-side decode: a sync sample always lands at address 0 and restarts the block.
   always_comb begin
      h_smp    = hmin(headroom(data_real_i), headroom(data_imag_i));
      h_acc    = hmin(h_run, h_smp);
      wr_en    = data_val_i && (block_sync_i || armed);
      wr_addr  = block_sync_i ? '0 : wr_cnt;
      close    = data_val_i && armed && !block_sync_i && (wr_cnt == AW'(BLK_LEN - 1));
      rd_last  = rd_busy && (rd_addr == AW'(BLK_LEN - 1));
      rd_start = full[rd_ptr] && (!rd_busy || rd_last);
      sh_amt   = int'(h_b) + MAN_WIDTH - IN_WIDTH;
      exp_b    = EXP_WIDTH'(IN_WIDTH - 1 - IN_PTPOS - int'(h_b));
   end

   // Writer: track fill position and running headroom; on close hand the bank to the reader.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         armed     <= 1'b0;
         wr_bank   <= 1'b0;
         wr_cnt    <= '0;
         h_run     <= '0;
         bank_h[0] <= '0;
         bank_h[1] <= '0;
      end else if (data_val_i) begin
         if (block_sync_i) begin
            armed  <= 1'b1;
            wr_cnt <= AW'(1);
            h_run  <= h_smp;
         end else if (close) begin
            armed           <= 1'b0;
            wr_cnt          <= '0;
            wr_bank         <= ~wr_bank;
            bank_h[wr_bank] <= h_acc;
         end else if (armed) begin
            wr_cnt <= wr_cnt + AW'(1);
            h_run  <= h_acc;
         end
      end
   end

   // Bank ownership: writer marks a bank full on close, reader claims it when replay starts.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         full <= '0;
      end else begin
         if (close) full[wr_bank] <= 1'b1;
         if (rd_start) full[rd_ptr] <= 1'b0;
      end
   end

   // Reader: sweep addresses 0..BLK_LEN-1; back-to-back blocks chain without a bubble.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         rd_busy <= 1'b0;
         rd_bank <= 1'b0;
         rd_ptr  <= 1'b0;
         rd_addr <= '0;
         rd_h    <= '0;
      end else if (rd_start) begin
         rd_busy <= 1'b1;
         rd_addr <= '0;
         rd_bank <= rd_ptr;
         rd_ptr  <= ~rd_ptr;
         rd_h    <= bank_h[rd_ptr];
      end else if (rd_last) begin
         rd_busy <= 1'b0;
      end else if (rd_busy) begin
         rd_addr <= rd_addr + AW'(1);
      end
   end

   // Sample buffer: one write port, one registered read port.
   always_ff @(posedge clk_sys) begin
      if (wr_en) mem[{wr_bank, wr_addr}] <= {data_real_i, data_imag_i};
      ram_q <= mem[{rd_bank, rd_addr}];
   end

   // Control delayed to line up with the registered RAM data.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         vld_b  <= 1'b0;
         sync_b <= 1'b0;
         h_b    <= '0;
      end else begin
         vld_b  <= rd_busy;
         sync_b <= rd_busy && (rd_addr == '0);
         h_b    <= rd_h;
      end
   end

   // Output stage: normalize and register; data and exponent hold while idle.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         data_val_o   <= 1'b0;
         block_sync_o <= 1'b0;
         data_real_o  <= '0;
         data_imag_o  <= '0;
         data_exp_o   <= '0;
      end else begin
         data_val_o   <= vld_b;
         block_sync_o <= sync_b;
         if (vld_b) begin
            data_real_o <= norm(ram_q[DW-1:IN_WIDTH], sh_amt);
            data_imag_o <= norm(ram_q[IN_WIDTH-1:0], sh_amt);
            data_exp_o  <= exp_b;
         end
      end
   end

endmodule

// File: tb/tb_fixed2bfp_block.sv
// Scoreboard bench: two instances (16-bit and 12-bit mantissas) share one input stream.
// Expected mantissas/exponents are pushed per sample; monitors pop on data_val_o.
// Block start cycles are checked against last-input-edge + 3.
module tb_fixed2bfp_block;

   logic clk_sys = 1'b0;
   logic rst_sys_n = 1'b0;
   logic block_sync_i = 1'b0;
   logic data_val_i = 1'b0;
   logic signed [15:0] data_real_i = '0;
   logic signed [15:0] data_imag_i = '0;

   logic sync16, val16, sync12, val12;
   logic signed [15:0] re16, im16;
   logic signed [11:0] re12, im12;
   logic signed [7:0]  exp16, exp12;

   always #5 clk_sys = ~clk_sys;

   fixed2bfp_block dut16 (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .block_sync_i(block_sync_i),
      .data_val_i(data_val_i), .data_real_i(data_real_i), .data_imag_i(data_imag_i),
      .block_sync_o(sync16), .data_val_o(val16), .data_real_o(re16),
      .data_imag_o(im16), .data_exp_o(exp16));

   fixed2bfp_block #(.MAN_WIDTH(12)) dut12 (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .block_sync_i(block_sync_i),
      .data_val_i(data_val_i), .data_real_i(data_real_i), .data_imag_i(data_imag_i),
      .block_sync_o(sync12), .data_val_o(val12), .data_real_o(re12),
      .data_imag_o(im12), .data_exp_o(exp12));

   typedef struct {
      int re;
      int im;
      int ex;
      bit sy;
   } exp_t;

   exp_t q16[$];
   exp_t q12[$];
   int   start_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_re16 = 0;
   int   last_exp16 = 0;
   int   b_re[64], b_im[64], e16_re[64], e16_im[64], e12_re[64], e12_im[64];
   int   b_exp;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic clear_block(input int ex);
      for (int i = 0; i < 64; i++) begin
         b_re[i] = 0; b_im[i] = 0;
         e16_re[i] = 0; e16_im[i] = 0;
         e12_re[i] = 0; e12_im[i] = 0;
      end
      b_exp = ex;
   endtask

   task automatic set_s(input int i, input int re, input int im,
                        input int r16, input int i16, input int r12, input int i12);
      b_re[i] = re; b_im[i] = im;
      e16_re[i] = r16; e16_im[i] = i16;
      e12_re[i] = r12; e12_im[i] = i12;
   endtask

   task automatic put(input bit v, input bit s, input int re, input int im);
      data_val_i   = v;
      block_sync_i = s;
      data_real_i  = 16'(re);
      data_imag_i  = 16'(im);
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle(input int n);
      data_val_i   = 1'b0;
      block_sync_i = 1'b0;
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // pre: junk samples (sync on the first) that a later resync must discard.
   task automatic send_block(input int pre, input bit gaps);
      exp_t e;
      for (int i = 0; i < pre; i++) put(1'b1, i == 0, 32767, -32768);
      for (int i = 0; i < 64; i++) begin
         if (gaps && (i % 4 == 3)) put(1'b0, 1'b1, 32767, 32767);
         e.re = e16_re[i]; e.im = e16_im[i]; e.ex = b_exp; e.sy = (i == 0);
         q16.push_back(e);
         e.re = e12_re[i]; e.im = e12_im[i];
         q12.push_back(e);
         put(1'b1, i == 0, b_re[i], b_im[i]);
      end
      start_q.push_back(cyc + 3);
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && (q16.size() > 0 || q12.size() > 0); n++) @(posedge clk_sys);
      #1;
      chk("drain16", q16.size(), 0);
      chk("drain12", q12.size(), 0);
      chk("drain_start", start_q.size(), 0);
   endtask

   task automatic count_cycles();
      forever begin
         @(posedge clk_sys);
         cyc++;
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk_sys);
         if (rst_sys_n) begin
            if (val16) begin
               if (q16.size() == 0) chk("unexpected_out16", 1, 0);
               else begin
                  e = q16.pop_front();
                  chk("re16", int'(re16), e.re);
                  chk("im16", int'(im16), e.im);
                  chk("exp16", int'(exp16), e.ex);
                  chk("sync16", int'(sync16), int'(e.sy));
                  last_re16  = e.re;
                  last_exp16 = e.ex;
               end
               if (sync16) begin
                  if (start_q.size() == 0) chk("unexpected_start", 1, 0);
                  else chk("start_cycle", cyc, start_q.pop_front());
               end
            end else begin
               chk("hold_re16", int'(re16), last_re16);
               chk("hold_exp16", int'(exp16), last_exp16);
               chk("sync_without_val16", int'(sync16), 0);
            end
            if (val12) begin
               if (q12.size() == 0) chk("unexpected_out12", 1, 0);
               else begin
                  e = q12.pop_front();
                  chk("re12", int'(re12), e.re);
                  chk("im12", int'(im12), e.im);
                  chk("exp12", int'(exp12), e.ex);
                  chk("sync12", int'(sync12), int'(e.sy));
               end
            end
         end
      end
   endtask

   task automatic watch_reset();
      forever begin
         @(negedge rst_sys_n);
         #1;
         chk("rst_val16", int'(val16), 0);
         chk("rst_sync16", int'(sync16), 0);
         chk("rst_re16", int'(re16), 0);
         chk("rst_im16", int'(im16), 0);
         chk("rst_exp16", int'(exp16), 0);
         chk("rst_val12", int'(val12), 0);
         chk("rst_re12", int'(re12), 0);
         q16.delete();
         q12.delete();
         start_q.delete();
         last_re16  = 0;
         last_exp16 = 0;
      end
   endtask

   initial begin
      fork
         count_cycles();
         monitor();
         watch_reset();
      join_none

      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      chk("init_val16", int'(val16), 0);
      chk("init_sync16", int'(sync16), 0);
      chk("init_re16", int'(re16), 0);
      chk("init_im16", int'(im16), 0);
      chk("init_exp16", int'(exp16), 0);
      chk("init_val12", int'(val12), 0);
      chk("init_exp12", int'(exp12), 0);
      rst_sys_n = 1'b1;
      idle(2);

      // Samples before any sync are dropped
      for (int i = 0; i < 5; i++) put(1'b1, 1'b0, 32767, -32768);

      // Single 0x0100 at index 5: h_min=6
      clear_block(-6);
      set_s(5, 256, 0, 16384, 0, 1024, 0);
      send_block(0, 1'b0);
      idle(5);
      drain();

      // All zeros, with input gaps
      clear_block(-15);
      send_block(0, 1'b1);
      idle(5);
      drain();

      // Full-scale negative forces exp 0; 12-bit instance exercises rounding
      clear_block(0);
      set_s(10, -32768, 1000, -32767, 1000, -2047, 63);
      set_s(12, -24, 24, -24, 24, -2, 2);
      set_s(13, -23, 23, -23, 23, -1, 1);
      set_s(14, 8, -8, 8, -8, 1, -1);
      set_s(15, 7, -7, 7, -7, 0, 0);
      send_block(0, 1'b0);
      idle(5);
      drain();

      // Positive full scale: 12-bit rounds to 2048 and saturates
      clear_block(0);
      set_s(0, 32767, 0, 32767, 0, 2047, 0);
      send_block(0, 1'b0);
      idle(5);
      drain();

      // Small values: large left shift, including -1
      clear_block(-11);
      set_s(0, 8, 0, 16384, 0, 1024, 0);
      set_s(3, 0, -1, 0, -2048, 0, -128);
      send_block(0, 1'b0);
      idle(5);
      drain();

      // Resync after 20 samples; discarded samples would otherwise force exp 0
      clear_block(-6);
      set_s(0, 256, 0, 16384, 0, 1024, 0);
      send_block(20, 1'b1);
      idle(5);
      drain();

      // Three gapless blocks
      clear_block(-6);
      set_s(5, 256, 0, 16384, 0, 1024, 0);
      send_block(0, 1'b0);
      clear_block(-15);
      send_block(0, 1'b0);
      clear_block(0);
      set_s(10, -32768, 1000, -32767, 1000, -2047, 63);
      send_block(0, 1'b0);
      idle(5);
      drain();

      // Reset while a block is streaming out and the next is half written
      clear_block(-6);
      for (int i = 0; i < 64; i++) set_s(i, 256, 0, 16384, 0, 1024, 0);
      send_block(0, 1'b0);
      for (int i = 0; i < 10; i++) put(1'b1, i == 0, 32767, 0);
      data_val_i   = 1'b0;
      block_sync_i = 1'b0;
      #1;
      rst_sys_n = 1'b0;
      repeat (3) @(posedge clk_sys);
      #3;
      rst_sys_n = 1'b1;
      idle(100);

      // Fresh block after reset
      clear_block(-6);
      set_s(5, 256, 0, 16384, 0, 1024, 0);
      send_block(0, 1'b0);
      idle(5);
      drain();
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
